// File: rtl/mem_port_arbiter.sv
// Shares one req/addr_ok/data_ok memory port between the fetch (inst) and memory (data) stages.
// Latency: request/accept pass through combinationally; responses are routed in the same cycle.
// Backpressure: no grant while MAX_OUTST requests are outstanding; mem_addr_ok stalls pass back.
module mem_port_arbiter #(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic        data_cache,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic        mem_cache,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err,
  output logic [31:0] perfcnt_inst_block
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // In-order source tags: 0 = inst, 1 = data.
  logic [MAX_OUTST-1:0] r_tag;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [STV_W-1:0]     r_starve;
  logic                 r_proto_err;
  logic [31:0]          r_perf;

  logic w_full;
  logic w_gnt_inst;
  logic w_gnt_data;
  logic w_push;
  logic w_pop;
  logic w_head_tag;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full = (r_count == CNT_W'(MAX_OUTST));

  // Grant: data normally wins a tie; inst wins once it has been starved long enough.
  always_comb begin
    w_gnt_inst = 1'b0;
    w_gnt_data = 1'b0;
    if (!w_full) begin
      if (inst_req && data_req) begin
        if (r_starve == STV_W'(STARVE_LIMIT)) begin
          w_gnt_inst = 1'b1;
        end else begin
          w_gnt_data = 1'b1;
        end
      end else begin
        w_gnt_inst = inst_req;
        w_gnt_data = data_req;
      end
    end
  end

  // Request fields come from the inst side whenever data is not granted.
  always_comb begin
    mem_req   = w_gnt_inst | w_gnt_data;
    mem_wr    = 1'b0;
    mem_size  = 2'd2;
    mem_cache = inst_cache;
    mem_addr  = inst_addr;
    mem_wdata = 32'd0;
    if (w_gnt_data) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_cache = data_cache;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign w_push     = mem_req & mem_addr_ok;
  assign w_pop      = mem_data_ok & (r_count != '0);
  assign w_head_tag = r_tag[r_head];

  assign inst_addr_ok       = mem_addr_ok & w_gnt_inst;
  assign data_addr_ok       = mem_addr_ok & w_gnt_data;
  assign inst_data_ok       = w_pop & ~w_head_tag;
  assign data_data_ok       = w_pop & w_head_tag;
  assign inst_rdata         = mem_rdata;
  assign data_rdata         = mem_rdata;
  assign proto_err          = r_proto_err;
  assign perfcnt_inst_block = r_perf;

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_tail] <= w_gnt_data;
    end
  end

  // Tracker pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= f_next(r_tail);
      if (w_pop)  r_head <= f_next(r_head);
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Starvation counter: saturating count of cycles inst waited behind data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve <= '0;
    end else if (w_gnt_inst && mem_addr_ok) begin
      r_starve <= '0;
    end else if (inst_req && w_gnt_data && (r_starve != STV_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_proto_err <= 1'b0;
    end else if (mem_data_ok && (r_count == '0)) begin
      r_proto_err <= 1'b1;
    end
  end

  // Count cycles where inst lost arbitration to data (wraps naturally).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_perf <= '0;
    end else if (inst_req && !w_gnt_inst && data_req && !w_full) begin
      r_perf <= r_perf + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an in-order response scoreboard.
// Latency: checks combinational outputs mid-cycle, registered state after the clock edge.
// Backpressure: exercises full-tracker blocking and starvation-driven priority.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr, data_cache;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr, mem_cache;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        proto_err;
  logic [31:0] perfcnt_inst_block;

  int n_pass;
  int n_total;
  logic sb_q[$];   // expected response source, 0 = inst, 1 = data

  mem_port_arbiter #(.MAX_OUTST(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_cache(data_cache),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_cache(mem_cache),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .proto_err(proto_err), .perfcnt_inst_block(perfcnt_inst_block)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_cache = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_cache = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    step(); step();
    resetn = 1;
    #1;
    n_total++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      $display("FAIL reset_outputs got=%b want=00000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end else n_pass++;
    n_total++;
    if ({proto_err, perfcnt_inst_block} !== 33'd0) begin
      $display("FAIL reset_state proto_err=%b perf=%0d want 0/0", proto_err, perfcnt_inst_block);
    end else n_pass++;
    step();
  endtask

  task automatic test_single_inst();
    logic s;
    idle();
    inst_req = 1; inst_cache = 1; inst_addr = 32'h0000_1000; mem_addr_ok = 1;
    #1;
    n_total++;
    if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b101) begin
      $display("FAIL single_inst_accept got=%b want=101", {inst_addr_ok, data_addr_ok, mem_req});
    end else n_pass++;
    n_total++;
    if ({mem_wr, mem_size, mem_cache, mem_addr, mem_wdata} !== {1'b0, 2'd2, 1'b1, 32'h0000_1000, 32'd0}) begin
      $display("FAIL single_inst_fields wr=%b size=%0d cache=%b addr=%h wdata=%h want 0/2/1/00001000/0",
               mem_wr, mem_size, mem_cache, mem_addr, mem_wdata);
    end else n_pass++;
    sb_q.push_back(1'b0);
    step();
    idle();
    #1;
    n_total++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      $display("FAIL single_inst_gap data_ok got=%b want=00", {inst_data_ok, data_data_ok});
    end else n_pass++;
    step();
    mem_data_ok = 1; mem_rdata = 32'hCAFE_0001;
    #1;
    s = sb_q.pop_front();
    n_total++;
    if ({inst_data_ok, data_data_ok} !== {~s, s}) begin
      $display("FAIL single_inst_route got=%b want=%b", {inst_data_ok, data_data_ok}, {~s, s});
    end else n_pass++;
    n_total++;
    if (inst_rdata !== 32'hCAFE_0001) begin
      $display("FAIL single_inst_rdata got=%h want=cafe0001", inst_rdata);
    end else n_pass++;
    step();
    idle();
  endtask

  task automatic test_data_fields();
    logic s;
    idle();
    data_req = 1; data_wr = 1; data_size = 2'd1; data_cache = 1;
    data_addr = 32'h8000_0042; data_wdata = 32'h1234_5678; mem_addr_ok = 1;
    inst_addr = 32'hDEAD_0000;
    #1;
    n_total++;
    if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b011) begin
      $display("FAIL data_accept got=%b want=011", {inst_addr_ok, data_addr_ok, mem_req});
    end else n_pass++;
    n_total++;
    if ({mem_wr, mem_size, mem_cache, mem_addr, mem_wdata} !== {1'b1, 2'd1, 1'b1, 32'h8000_0042, 32'h1234_5678}) begin
      $display("FAIL data_fields wr=%b size=%0d cache=%b addr=%h wdata=%h want 1/1/1/80000042/12345678",
               mem_wr, mem_size, mem_cache, mem_addr, mem_wdata);
    end else n_pass++;
    sb_q.push_back(1'b1);
    step();
    idle();
    mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D;
    #1;
    s = sb_q.pop_front();
    n_total++;
    if ({inst_data_ok, data_data_ok, data_rdata} !== {~s, s, 32'h0BAD_F00D}) begin
      $display("FAIL data_route got=%b/%h want=%b/0badf00d", {inst_data_ok, data_data_ok}, data_rdata, {~s, s});
    end else n_pass++;
    step();
    idle();
  endtask

  task automatic test_starvation();
    logic s;
    logic [31:0] rd;
    for (int i = 0; i <= 8; i++) begin
      idle();
      inst_req = 1; data_req = 1; mem_addr_ok = 1;
      mem_data_ok = (sb_q.size() != 0);
      rd = 32'hD000_0000 + 32'(i);
      mem_rdata = rd;
      #1;
      n_total++;
      if ({inst_addr_ok, data_addr_ok} !== {i == 8, i < 8}) begin
        $display("FAIL starve_grant cycle=%0d got=%b want=%b", i, {inst_addr_ok, data_addr_ok},
                 {i == 8, i < 8});
      end else n_pass++;
      if (mem_data_ok) begin
        s = sb_q.pop_front();
        n_total++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {~s, s, rd}) begin
          $display("FAIL starve_route cycle=%0d got=%b/%h want=%b/%h", i,
                   {inst_data_ok, data_data_ok}, inst_rdata, {~s, s}, rd);
        end else n_pass++;
      end
      sb_q.push_back((i < 8) ? 1'b1 : 1'b0);
      step();
    end
    idle();
    mem_data_ok = 1; mem_rdata = 32'hD000_00FF;
    #1;
    s = sb_q.pop_front();
    n_total++;
    if ({inst_data_ok, data_data_ok} !== {~s, s}) begin
      $display("FAIL starve_drain got=%b want=%b", {inst_data_ok, data_data_ok}, {~s, s});
    end else n_pass++;
    n_total++;
    if (perfcnt_inst_block !== 32'd8) begin
      $display("FAIL starve_perfcnt got=%0d want=8", perfcnt_inst_block);
    end else n_pass++;
    step();
    idle();
  endtask

  task automatic test_full();
    logic s;
    // Fill the tracker with four inst requests.
    for (int i = 0; i < 4; i++) begin
      idle();
      inst_req = 1; inst_addr = 32'h100 + 32'(4 * i); mem_addr_ok = 1;
      #1;
      n_total++;
      if (inst_addr_ok !== 1'b1) begin
        $display("FAIL full_fill cycle=%0d inst_addr_ok got=%b want=1", i, inst_addr_ok);
      end else n_pass++;
      sb_q.push_back(1'b0);
      step();
    end
    // Full: a same-cycle response does not open the port this cycle.
    idle();
    inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hF011_0000;
    #1;
    n_total++;
    if ({mem_req, inst_addr_ok} !== 2'b00) begin
      $display("FAIL full_block got=%b want=00", {mem_req, inst_addr_ok});
    end else n_pass++;
    s = sb_q.pop_front();
    n_total++;
    if ({inst_data_ok, data_data_ok} !== {~s, s}) begin
      $display("FAIL full_pop_route got=%b want=%b", {inst_data_ok, data_data_ok}, {~s, s});
    end else n_pass++;
    step();
    // Next cycle acceptance resumes.
    mem_data_ok = 0;
    #1;
    n_total++;
    if ({mem_req, inst_addr_ok} !== 2'b11) begin
      $display("FAIL full_resume got=%b want=11", {mem_req, inst_addr_ok});
    end else n_pass++;
    sb_q.push_back(1'b0);
    step();
    // Drain one (count 3), then push+pop together (count stays 3).
    idle();
    mem_data_ok = 1;
    #1;
    s = sb_q.pop_front();
    step();
    inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    s = sb_q.pop_front();
    n_total++;
    if ({inst_addr_ok, inst_data_ok, data_data_ok} !== {1'b1, ~s, s}) begin
      $display("FAIL pushpop got=%b want=%b", {inst_addr_ok, inst_data_ok, data_data_ok}, {1'b1, ~s, s});
    end else n_pass++;
    sb_q.push_back(1'b0);
    step();
    mem_data_ok = 0;
    #1;
    n_total++;
    if (inst_addr_ok !== 1'b1) begin
      $display("FAIL pushpop_count_room inst_addr_ok got=%b want=1", inst_addr_ok);
    end else n_pass++;
    sb_q.push_back(1'b0);
    step();
    #1;
    n_total++;
    if (mem_req !== 1'b0) begin
      $display("FAIL pushpop_count_full mem_req got=%b want=0", mem_req);
    end else n_pass++;
    // Drain everything.
    idle();
    while (sb_q.size() != 0) begin
      mem_data_ok = 1;
      #1;
      s = sb_q.pop_front();
      n_total++;
      if ({inst_data_ok, data_data_ok} !== {~s, s}) begin
        $display("FAIL full_drain got=%b want=%b", {inst_data_ok, data_data_ok}, {~s, s});
      end else n_pass++;
      step();
    end
    idle();
  endtask

  task automatic test_interleave();
    logic s;
    logic [3:0] order;
    logic [31:0] rd;
    order = 4'b0110;   // I, D, D, I (bit i = source of request i)
    for (int i = 0; i < 4; i++) begin
      idle();
      mem_addr_ok = 1;
      if (order[i]) data_req = 1; else inst_req = 1;
      #1;
      n_total++;
      if ({inst_addr_ok, data_addr_ok} !== {~order[i], order[i]}) begin
        $display("FAIL interleave_accept idx=%0d got=%b want=%b", i, {inst_addr_ok, data_addr_ok},
                 {~order[i], order[i]});
      end else n_pass++;
      sb_q.push_back(order[i]);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      rd = 32'hA5A5_0000 + 32'(i);
      mem_data_ok = 1; mem_rdata = rd;
      #1;
      s = sb_q.pop_front();
      n_total++;
      if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== {~s, s, rd, rd}) begin
        $display("FAIL interleave_route idx=%0d got=%b/%h/%h want=%b/%h", i,
                 {inst_data_ok, data_data_ok}, inst_rdata, data_rdata, {~s, s}, rd);
      end else n_pass++;
      step();
    end
    idle();
  endtask

  task automatic test_proto_and_reset();
    idle();
    mem_data_ok = 1;
    #1;
    n_total++;
    if ({inst_data_ok, data_data_ok, proto_err} !== 3'b000) begin
      $display("FAIL proto_empty got=%b want=000", {inst_data_ok, data_data_ok, proto_err});
    end else n_pass++;
    step();
    idle();
    step(); step();
    n_total++;
    if (proto_err !== 1'b1) begin
      $display("FAIL proto_sticky got=%b want=1", proto_err);
    end else n_pass++;
    // Three outstanding, then reset.
    for (int i = 0; i < 3; i++) begin
      inst_req = 1; mem_addr_ok = 1;
      sb_q.push_back(1'b0);
      step();
    end
    idle();
    resetn = 0;
    step();
    resetn = 1;
    sb_q.delete();
    #1;
    n_total++;
    if ({proto_err, perfcnt_inst_block} !== 33'd0) begin
      $display("FAIL midreset_state proto_err=%b perf=%0d want 0/0", proto_err, perfcnt_inst_block);
    end else n_pass++;
    mem_data_ok = 1;
    #1;
    n_total++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      $display("FAIL midreset_no_route got=%b want=00", {inst_data_ok, data_data_ok});
    end else n_pass++;
    step();
    idle();
    // Count restarted at zero: four accepts fit, the fifth is blocked.
    for (int i = 0; i < 5; i++) begin
      inst_req = 1; mem_addr_ok = 1;
      #1;
      n_total++;
      if (inst_addr_ok !== (i < 4)) begin
        $display("FAIL midreset_count idx=%0d inst_addr_ok got=%b want=%b", i, inst_addr_ok, i < 4);
      end else n_pass++;
      step();
    end
    idle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    resetn  = 0;
    idle();
    test_reset();
    test_single_inst();
    test_data_fields();
    test_starvation();
    test_full();
    test_interleave();
    test_proto_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
